xgmii_frame_switch: RTL

- Parametrised single-clock crossbar for 32-bit XGMII columns, generalising fixed one-source-to-many retransmit fan-out into NUM_IN sources and NUM_OUT destinations.
- Route of each output is runtime-selectable. Route changes take effect only at frame boundaries, so no destination ever sees a partial frame.
- Sits after the rx-to-tx clock-domain FIFOs, on the common tx clock, feeding pcs_tx_32b instances.

---
 rtl/xgmii_frame_switch.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_frame_switch.sv
// xgmii_frame_switch: NUM_IN x NUM_OUT crossbar for 32-bit XGMII columns on
// the common tx clock. Each destination runs its own IDLE/FRAME machine so a
// route change only lands between frames, and a broken or over-long frame is
// closed with an Abort column (0xFDFEFEFE / 0xF).
// Optional per-destination frame/abort counters: define XGMII_SWITCH_STATS_EN.
module xgmii_frame_switch #(
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 3,
  parameter int MAX_COLS = 2500,
  localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*32-1:0]     in_data,
  input  logic [NUM_IN*4-1:0]      in_ctrl,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_OUT-1:0]       out_en,
  input  logic [NUM_OUT*SEL_W-1:0] sel_in,
  input  logic [NUM_OUT-1:0]       sel_we,
  output logic [NUM_OUT*SEL_W-1:0] sel_out,
  output logic [NUM_OUT*32-1:0]    out_data,
  output logic [NUM_OUT*4-1:0]     out_ctrl,
  output logic [NUM_OUT-1:0]       out_busy
`ifdef XGMII_SWITCH_STATS_EN
  ,
  output logic [NUM_OUT*32-1:0]    frm_cnt,
  output logic [NUM_OUT*16-1:0]    abort_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_COLS + 1);

  localparam logic [31:0] IDLE_D  = 32'h07070707;
  localparam logic [3:0]  IDLE_C  = 4'hF;
  localparam logic [31:0] ABORT_D = 32'hFDFEFEFE;
  localparam logic [3:0]  ABORT_C = 4'hF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Start of frame: lane 0 carries the /S/ control character.
  function automatic logic is_start(input logic [31:0] d, input logic [3:0] c);
    return c[0] && (d[7:0] == 8'hFB);
  endfunction

  // End of frame: /T/ control character in any lane.
  function automatic logic is_term(input logic [31:0] d, input logic [3:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit = hit | (c[i] && (d[i*8 +: 8] == 8'hFD));
    end
    return hit;
  endfunction

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_dst
    logic [0:0]       state_r, state_nx_s;
    logic [SEL_W-1:0] sel_r, sel_nx_s;
    logic [SEL_W-1:0] pend_r, pend_nx_s;
    logic             pend_vld_r, pend_vld_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [31:0]      out_d_r, out_d_nx_s;
    logic [3:0]       out_c_r, out_c_nx_s;
    logic             busy_r, busy_nx_s;
    logic [31:0]      src_d_s;
    logic [3:0]       src_c_s;
    logic             src_vld_s;
    logic [SEL_W-1:0] sel_field_s;
    logic             sel_ok_s;
    logic             abort_s;
    logic             term_s;
    logic             start_s;

    assign sel_field_s = sel_in[j*SEL_W +: SEL_W];
    assign sel_ok_s    = (int'(sel_field_s) < NUM_IN);
    assign term_s      = is_term(src_d_s, src_c_s);
    assign start_s     = is_start(src_d_s, src_c_s);
    assign abort_s     = (state_r == ST_FRAME) &&
                         (!src_vld_s || !out_en[j] || (cnt_r == CNT_W'(MAX_COLS)));

    // Source multiplexer driven by the active select.
    always_comb begin
      src_d_s   = IDLE_D;
      src_c_s   = IDLE_C;
      src_vld_s = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
        src_d_s   = (sel_r == SEL_W'(k)) ? in_data[k*32 +: 32] : src_d_s;
        src_c_s   = (sel_r == SEL_W'(k)) ? in_ctrl[k*4 +: 4]   : src_c_s;
        src_vld_s = (sel_r == SEL_W'(k)) ? in_valid[k]         : src_vld_s;
      end
    end

    // Frame FSM, select application and next output column.
    always_comb begin
      state_nx_s    = state_r;
      sel_nx_s      = sel_r;
      pend_nx_s     = pend_r;
      pend_vld_nx_s = pend_vld_r;
      cnt_nx_s      = cnt_r;
      out_d_nx_s    = IDLE_D;
      out_c_nx_s    = IDLE_C;
      busy_nx_s     = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pend_vld_r) begin
            // A pending route blocks frame entry, so the machine stays idle
            // this cycle and the switch is safe; any Start here is dropped.
            sel_nx_s      = pend_r;
            pend_vld_nx_s = 1'b0;
          end else if (out_en[j] && src_vld_s && start_s) begin
            state_nx_s = ST_FRAME;
            cnt_nx_s   = CNT_W'(1);
            out_d_nx_s = src_d_s;
            out_c_nx_s = src_c_s;
            busy_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_FRAME: begin
          busy_nx_s = 1'b1;
          if (abort_s) begin
            // Abort takes priority over a Terminate in the same column.
            state_nx_s = ST_IDLE;
            out_d_nx_s = ABORT_D;
            out_c_nx_s = ABORT_C;
          end else if (term_s) begin
            state_nx_s = ST_IDLE;
            out_d_nx_s = src_d_s;
            out_c_nx_s = src_c_s;
          end else begin
            cnt_nx_s   = cnt_r + CNT_W'(1);
            out_d_nx_s = src_d_s;
            out_c_nx_s = src_c_s;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
      // A fresh write is recorded after any application so it is not lost.
      if (sel_we[j] && sel_ok_s) begin
        pend_nx_s     = sel_field_s;
        pend_vld_nx_s = 1'b1;
      end else begin
        pend_nx_s = pend_nx_s;
      end
    end

    // Destination state and registered output column.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_r    <= ST_IDLE;
        sel_r      <= '0;
        pend_r     <= '0;
        pend_vld_r <= 1'b0;
        cnt_r      <= '0;
        out_d_r    <= IDLE_D;
        out_c_r    <= IDLE_C;
        busy_r     <= 1'b0;
      end else begin
        state_r    <= state_nx_s;
        sel_r      <= sel_nx_s;
        pend_r     <= pend_nx_s;
        pend_vld_r <= pend_vld_nx_s;
        cnt_r      <= cnt_nx_s;
        out_d_r    <= out_d_nx_s;
        out_c_r    <= out_c_nx_s;
        busy_r     <= busy_nx_s;
      end
    end

    assign out_data[j*32 +: 32]     = out_d_r;
    assign out_ctrl[j*4 +: 4]       = out_c_r;
    assign out_busy[j]              = busy_r;
    assign sel_out[j*SEL_W +: SEL_W] = sel_r;

`ifdef XGMII_SWITCH_STATS_EN
    logic [31:0] frm_cnt_r;
    logic [15:0] abort_cnt_r;

    // Frame and abort exit counters, wrapping on overflow.
    always_ff @(posedge clk) begin
      if (!rst) begin
        frm_cnt_r   <= 32'd0;
        abort_cnt_r <= 16'd0;
      end else if (abort_s) begin
        abort_cnt_r <= abort_cnt_r + 16'd1;
      end else if ((state_r == ST_FRAME) && term_s) begin
        frm_cnt_r <= frm_cnt_r + 32'd1;
      end else begin
        frm_cnt_r <= frm_cnt_r;
      end
    end

    assign frm_cnt[j*32 +: 32]   = frm_cnt_r;
    assign abort_cnt[j*16 +: 16] = abort_cnt_r;
`endif
  end

endmodule
